// File: rtl/ahb_vga_pkg.sv
// Shared constants for the AHB-to-VGA write bridge: register offsets, FSM encoding, cell geometry.
package ahb_vga_pkg;

  localparam logic [11:0] OFS_CLEAR  = 12'h800;
  localparam logic [11:0] OFS_STATUS = 12'h804;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam int unsigned CELL_V_W   = 4;
  localparam int unsigned CELL_H_W   = 5;
  localparam int unsigned CELL_CNT   = 512;
  localparam int unsigned CELL_CNT_W = CELL_V_W + CELL_H_W;
  localparam int unsigned ENTRY_W    = CELL_V_W + CELL_H_W + 32;

endpackage

// File: rtl/vga_wr_fifo.sv
// Synchronous write FIFO with wrap-bit pointers; push/pop are only asserted when legal.
module vga_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 41,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rd[AW-1:0]];
  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign count = r_wr - r_rd;

endmodule

// File: rtl/ahb_vga_bridge.sv
// AHB-Lite slave mapping the 16x32 character grid onto VGA write strobes, with a
// buffered write path and a hardware clear engine.
module ahb_vga_bridge
  import ahb_vga_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ISSUE_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HSEL,
  input  logic [11:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [3:0]  vga_addr_v,
  output logic [4:0]  vga_addr_h,
  output logic [31:0] vga_ctrl,
  output logic        vga_ctrl_en
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  logic                  r_dp_valid, r_dp_write;
  logic [11:0]           r_dp_addr;
  logic [2:0]            r_dp_size;
  logic [1:0]            r_state;
  logic [CELL_CNT_W-1:0] r_cnt;
  logic [31:0]           r_fill;
  logic [GAP_W-1:0]      r_gap;
  logic [CELL_V_W-1:0]   r_v;
  logic [CELL_H_W-1:0]   r_h;
  logic [31:0]           r_ctrl;

  logic               w_word, w_cell_wr, w_clr_wr, w_idle, w_gap_ok;
  logic               w_push, w_pop, w_clr_issue, w_issue, w_full, w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [3:0]         w_cnt4;
  logic [ENTRY_W-1:0] w_din, w_dout, w_iss;
  logic [31:0]        w_status;
  logic               unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
      r_dp_size  <= '0;
    end else if (HREADY) begin
      r_dp_valid <= HSEL & HTRANS[1];
      r_dp_write <= HWRITE;
      r_dp_addr  <= HADDR;
      r_dp_size  <= HSIZE;
    end
  end

  assign w_word    = r_dp_valid & r_dp_write & (r_dp_size == 3'b010);
  assign w_cell_wr = w_word & ~r_dp_addr[11];
  assign w_clr_wr  = w_word & (r_dp_addr == OFS_CLEAR);
  assign w_idle    = (r_state == ST_IDLE);
  assign w_gap_ok  = (r_gap == '0);

  // Wait states depend only on registered state, never on the current address phase.
  assign HREADYOUT = ~((w_cell_wr & (w_full | ~w_idle)) | (w_clr_wr & ~w_idle));
  assign HRESP     = 1'b0;

  assign w_cnt4   = 4'(w_count);
  assign w_status = {24'd0, w_cnt4, 3'd0, ~w_idle};
  assign HRDATA   = (r_dp_valid & ~r_dp_write & (r_dp_addr == OFS_STATUS)) ? w_status : '0;

  assign w_push = w_cell_wr & ~w_full & w_idle;
  assign w_din  = {r_dp_addr[10:7], r_dp_addr[6:2], HWDATA};

  vga_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_pop       = (r_state != ST_CLEAR) & ~w_empty & w_gap_ok;
  assign w_clr_issue = (r_state == ST_CLEAR) & w_gap_ok;
  assign w_issue     = w_pop | w_clr_issue;
  assign w_iss       = w_clr_issue ? {r_cnt, r_fill} : w_dout;

  assign vga_ctrl_en = w_issue;
  assign vga_addr_v  = w_issue ? w_iss[40:37] : r_v;
  assign vga_addr_h  = w_issue ? w_iss[36:32] : r_h;
  assign vga_ctrl    = w_issue ? w_iss[31:0]  : r_ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gap  <= '0;
      r_v    <= '0;
      r_h    <= '0;
      r_ctrl <= '0;
    end else if (w_issue) begin
      r_gap  <= GAP_W'(ISSUE_GAP - 1);
      r_v    <= w_iss[40:37];
      r_h    <= w_iss[36:32];
      r_ctrl <= w_iss[31:0];
    end else if (!w_gap_ok) begin
      r_gap <= r_gap - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_fill  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_clr_wr) begin
            r_state <= ST_PEND;
            r_fill  <= HWDATA;
          end
        end
        // Earlier cell writes drain before the fill starts.
        ST_PEND: begin
          r_cnt <= '0;
          if (w_empty) r_state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (w_clr_issue) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CELL_CNT_W'(CELL_CNT - 1)) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_vga_bridge.sv
// Directed bench for ahb_vga_bridge: bus writes/reads, pulse log, hand-computed expectations.
module tb_ahb_vga_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [11:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA, HRDATA;
  logic [3:0]  vga_addr_v;
  logic [4:0]  vga_addr_h;
  logic [31:0] vga_ctrl;
  logic        vga_ctrl_en;

  always #5 clk = ~clk;
  assign HREADY = HREADYOUT;

  ahb_vga_bridge #(
    .FIFO_DEPTH (4),
    .ISSUE_GAP  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HREADYOUT   (HREADYOUT),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .vga_addr_v  (vga_addr_v),
    .vga_addr_h  (vga_addr_h),
    .vga_ctrl    (vga_ctrl),
    .vga_ctrl_en (vga_ctrl_en)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  pv [4096];
  logic [4:0]  ph [4096];
  logic [31:0] pc [4096];
  int          pt [4096];
  int          np = 0;

  always @(negedge clk) begin
    if (vga_ctrl_en === 1'b1 && np < 4096) begin
      pv[np] = vga_addr_v;
      ph[np] = vga_addr_h;
      pc[np] = vga_ctrl;
      pt[np] = cyc;
      np = np + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic [11:0] wa [8];
  logic [31:0] wd [8];
  logic [2:0]  ws [8];
  int          dp_cyc [8];
  int          g_cyc;
  int          stalls;
  logic [31:0] rdata;

  // Completes the current bus cycle, waiting out any wait states.
  task automatic wait_ready();
    int n;
    n = 0;
    while (HREADYOUT !== 1'b1 && n < 4000) begin
      @(posedge clk); #1;
      n++;
      stalls++;
    end
    if (n >= 4000) begin
      n_checks++;
      n_errors++;
      $display("FAIL hready_timeout: got %0d stall cycles, required fewer than 4000", n);
    end
    g_cyc = cyc;
    rdata = HRDATA;
    @(posedge clk); #1;
  endtask

  task automatic run_writes(input int n);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = wa[i]; HSIZE = ws[i];
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00;
      end
      if (i > 0) HWDATA = wd[i-1];
      wait_ready();
      if (i > 0) dp_cyc[i-1] = g_cyc;
    end
  endtask

  task automatic bus_read(input logic [11:0] a);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HSIZE = 3'b010;
    wait_ready();
    HSEL = 1'b0; HTRANS = 2'b00;
    wait_ready();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int n;
    n = 0;
    while (np < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (np < target) begin
      n_checks++;
      n_errors++;
      $display("FAIL pulse_timeout: got %0d pulses, required %0d", np, target);
    end
  endtask

  int base, bad, k;

  initial begin
    rst_n = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = '0; HSIZE = 3'b000; HWDATA = '0; stalls = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);

    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_addr_v", 32'(vga_addr_v), 32'd0);
    check("rst_addr_h", 32'(vga_addr_h), 32'd0);
    check("rst_ctrl", vga_ctrl, 32'd0);
    check("rst_no_pulse", 32'(np), 32'd0);

    // Single write: 0x0A8 -> row 1, column 10.
    wa[0] = 12'h0A8; wd[0] = 32'h0000_1234; ws[0] = 3'b010;
    run_writes(1);
    idle(5);
    check("single_count", 32'(np), 32'd1);
    check("single_v", 32'(pv[0]), 32'd1);
    check("single_h", 32'(ph[0]), 32'd10);
    check("single_ctrl", pc[0], 32'h0000_1234);
    check("single_latency", 32'(pt[0] - dp_cyc[0]), 32'd1);
    check("hold_en", 32'(vga_ctrl_en), 32'd0);
    check("hold_v", 32'(vga_addr_v), 32'd1);
    check("hold_ctrl", vga_ctrl, 32'h0000_1234);

    // Six back-to-back writes along row 2.
    base = np;
    for (int i = 0; i < 6; i++) begin
      wa[i] = 12'h100 + 12'(4 * i); wd[i] = 32'hA000 + 32'(i); ws[i] = 3'b010;
    end
    run_writes(6);
    idle(20);
    check("burst_count", 32'(np - base), 32'd6);
    check("burst_latency", 32'(pt[base] - dp_cyc[0]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("burst_v%0d", i), 32'(pv[base+i]), 32'd2);
      check($sformatf("burst_h%0d", i), 32'(ph[base+i]), 32'(i));
      check($sformatf("burst_ctrl%0d", i), pc[base+i], 32'hA000 + 32'(i));
      if (i > 0) check($sformatf("burst_gap%0d", i), 32'(pt[base+i] - pt[base+i-1]), 32'd2);
    end

    // Three writes then a CLEAR: writes land first, then 512 fill pulses.
    base = np;
    wa[0] = 12'h000; wd[0] = 32'h11; ws[0] = 3'b010;
    wa[1] = 12'h784; wd[1] = 32'h22; ws[1] = 3'b010;
    wa[2] = 12'h3FC; wd[2] = 32'h33; ws[2] = 3'b010;
    wa[3] = 12'h800; wd[3] = 32'h20; ws[3] = 3'b010;
    run_writes(4);
    idle(20);
    bus_read(12'h804);
    check("status_busy", rdata, 32'h0000_0001);
    wait_pulses(base + 515, 3000);
    idle(5);
    bus_read(12'h804);
    check("status_done", rdata, 32'h0000_0000);
    bus_read(12'h0A8);
    check("cell_read_zero", rdata, 32'h0000_0000);
    check("clr_count", 32'(np - base), 32'd515);
    check("pre_v0", 32'(pv[base]), 32'd0);
    check("pre_ctrl0", pc[base], 32'h11);
    check("pre_v1", 32'(pv[base+1]), 32'd15);
    check("pre_h1", 32'(ph[base+1]), 32'd1);
    check("pre_ctrl1", pc[base+1], 32'h22);
    check("pre_v2", 32'(pv[base+2]), 32'd7);
    check("pre_h2", 32'(ph[base+2]), 32'd31);
    check("pre_ctrl2", pc[base+2], 32'h33);
    bad = 0;
    for (int j = 0; j < 512; j++) begin
      k = base + 3 + j;
      if (pv[k] !== 4'(j >> 5) || ph[k] !== 5'(j & 31) || pc[k] !== 32'h20) bad++;
      if (j > 0 && pt[k] - pt[k-1] != 2) bad++;
    end
    check("clr_cells_bad", 32'(bad), 32'd0);

    // Cell write issued during a clear stalls, then becomes pulse 513.
    base = np;
    wa[0] = 12'h800; wd[0] = 32'h77; ws[0] = 3'b010;
    run_writes(1);
    idle(10);
    stalls = 0;
    wa[0] = 12'h7FC; wd[0] = 32'hABCD; ws[0] = 3'b010;
    run_writes(1);
    idle(10);
    check("stall_seen", 32'(stalls > 500), 32'd1);
    check("late_count", 32'(np - base), 32'd513);
    check("late_last_fill", pc[base+511], 32'h77);
    check("late_v", 32'(pv[base+512]), 32'd15);
    check("late_h", 32'(ph[base+512]), 32'd31);
    check("late_ctrl", pc[base+512], 32'hABCD);
    check("late_gap", 32'(pt[base+512] - pt[base+511]), 32'd2);

    // Reset right after cell 100 of a clear.
    base = np;
    wa[0] = 12'h800; wd[0] = 32'h55; ws[0] = 3'b010;
    run_writes(1);
    wait_pulses(base + 101, 1000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(30);
    check("rst_mid_count", 32'(np - base), 32'd101);
    check("rst_mid_v", 32'(pv[base+100]), 32'd3);
    check("rst_mid_h", 32'(ph[base+100]), 32'd4);
    check("rst_mid_out_v", 32'(vga_addr_v), 32'd0);
    check("rst_mid_out_ctrl", vga_ctrl, 32'd0);
    bus_read(12'h804);
    check("rst_mid_status", rdata, 32'h0000_0000);
    base = np;
    wa[0] = 12'h000; wd[0] = 32'hFFFF; ws[0] = 3'b001;
    run_writes(1);
    idle(10);
    check("halfword_no_pulse", 32'(np - base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
